mem_stage: RTL and testbench

- Pipeline stage downstream of the execute stage. Consumes the ALU result as the effective address and register operand 2 as store data.
- Performs RV32I loads and stores over a req/ack data-memory port, with byte-lane steering and sign/zero extension.
- Presents registered writeback data to the WB stage.
- Asserts a stall to upstream stages while a memory transaction is outstanding.

---
 rtl/mem_pkg.sv | 43 ++++
 rtl/load_align.sv | 32 +++
 rtl/mem_stage.sv | 151 +++++++++++++++
 tb/tb_mem_stage.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared constants and types for the memory-access pipeline stage.
package mem_pkg;

  // RV32I load/store funct3 encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Byte-enable patterns (byte pattern is shifted by the address offset)
  localparam logic [3:0] BE_BYTE    = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

  // Access size; loads also decode the unsigned variants, while unknown
  // encodings fall back to a full word for both loads and stores.
  function automatic size_t access_size(input logic [2:0] funct3, input logic is_store);
    size_t sz;
    sz = SZ_W;
    if (is_store) begin
      if (funct3 == F3_B) sz = SZ_B;
      else if (funct3 == F3_H) sz = SZ_H;
    end else begin
      if (funct3 == F3_B || funct3 == F3_BU) sz = SZ_B;
      else if (funct3 == F3_H || funct3 == F3_HU) sz = SZ_H;
    end
    return sz;
  endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/half of a read word and sign/zero extends it.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] load_value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection followed by extension according to funct3
  always_comb begin
    case (addr)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    load_value = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_value = {{16{half_sel[15]}}, half_sel};
      F3_BU:   load_value = {24'd0, byte_sel};
      F3_HU:   load_value = {16'd0, half_sel};
      default: load_value = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: issues RV32I loads/stores over a req/ack port, stalls
// upstream while a request is outstanding, and presents registered WB data.
module mem_stage
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic [XLEN-1:0] ex_store_data,
  input  logic [2:0]      ex_funct3,
  input  logic            ex_mem_read,
  input  logic            ex_mem_write,
  input  logic [4:0]      ex_rd,
  input  logic            ex_reg_write,
  output logic            mem_stall,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic            wb_reg_write,
  output logic [XLEN-1:0] wb_data,
  output logic            misalign
);

  state_t      state;
  logic        is_store;
  logic        is_mem;
  size_t       size;
  logic        misaligned;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;

  // Context of the outstanding access, needed when the ack returns
  logic        pend_load;
  logic        pend_reg_write;
  logic [4:0]  pend_rd;
  logic [2:0]  pend_funct3;
  logic [1:0]  pend_off;
  logic [31:0] load_value;

  assign mem_stall = (state == S_WAIT);

  // Decode the EX request: size, alignment, lane enables and replicated data
  always_comb begin
    is_store   = ex_mem_write;
    is_mem     = ex_mem_write | ex_mem_read;
    size       = access_size(ex_funct3, is_store);
    misaligned = 1'b0;
    be_next    = BE_WORD;
    wdata_next = ex_store_data;
    case (size)
      SZ_B: begin
        be_next    = BE_BYTE << ex_alu_result[1:0];
        wdata_next = {4{ex_store_data[7:0]}};
      end
      SZ_H: begin
        misaligned = ex_alu_result[0];
        be_next    = ex_alu_result[1] ? BE_HALF_HI : BE_HALF_LO;
        wdata_next = {2{ex_store_data[15:0]}};
      end
      default: begin
        misaligned = (ex_alu_result[1:0] != 2'b00);
      end
    endcase
  end

  load_align u_load_align (
    .rdata      (dmem_rdata),
    .addr       (pend_off),
    .funct3     (pend_funct3),
    .load_value (load_value)
  );

  // IDLE/WAIT controller with registered memory-port and writeback outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      dmem_req       <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_wdata     <= '0;
      dmem_be        <= 4'd0;
      wb_valid       <= 1'b0;
      wb_rd          <= 5'd0;
      wb_reg_write   <= 1'b0;
      wb_data        <= '0;
      misalign       <= 1'b0;
      pend_load      <= 1'b0;
      pend_reg_write <= 1'b0;
      pend_rd        <= 5'd0;
      pend_funct3    <= 3'd0;
      pend_off       <= 2'd0;
    end else begin
      wb_valid <= 1'b0;
      misalign <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ex_valid) begin
            if (!is_mem) begin
              wb_valid     <= 1'b1;
              wb_data      <= ex_alu_result;
              wb_rd        <= ex_rd;
              wb_reg_write <= ex_reg_write;
            end else if (misaligned) begin
              wb_valid     <= 1'b1;
              misalign     <= 1'b1;
              wb_data      <= '0;
              wb_rd        <= ex_rd;
              wb_reg_write <= 1'b0;
            end else begin
              state          <= S_WAIT;
              dmem_req       <= 1'b1;
              dmem_we        <= is_store;
              dmem_addr      <= {ex_alu_result[XLEN-1:2], 2'b00};
              dmem_be        <= be_next;
              dmem_wdata     <= wdata_next;
              pend_load      <= ~is_store;
              pend_reg_write <= ex_reg_write;
              pend_rd        <= ex_rd;
              pend_funct3    <= ex_funct3;
              pend_off       <= ex_alu_result[1:0];
            end
          end
        end
        S_WAIT: begin
          if (dmem_ack) begin
            state    <= S_IDLE;
            dmem_req <= 1'b0;
            wb_valid <= 1'b1;
            wb_rd    <= pend_rd;
            if (pend_load) begin
              wb_data      <= load_value;
              wb_reg_write <= pend_reg_write;
            end else begin
              wb_reg_write <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed table, randomized vectors
// against an arithmetic reference model, and multi-cycle corner sequences.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  logic [2:0]  ex_funct3;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        mem_stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic [31:0] wb_data;
  logic        misalign;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_stage #(.XLEN(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .ex_alu_result (ex_alu_result),
    .ex_store_data (ex_store_data),
    .ex_funct3     (ex_funct3),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .mem_stall     (mem_stall),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_be       (dmem_be),
    .dmem_ack      (dmem_ack),
    .dmem_rdata    (dmem_rdata),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .wb_data       (wb_data),
    .misalign      (misalign)
  );

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        rw;
    int          delay;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_wb;
    logic        exp_mis;
    logic        exp_rw;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ld, input logic st, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] sdata,
                              input logic [31:0] rdata, input logic [4:0] rd, input logic rw,
                              input int delay, input logic exp_req, input logic [31:0] exp_addr,
                              input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                              input logic [31:0] exp_wb, input logic exp_mis, input logic exp_rw);
    vec_t v;
    v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.sdata = sdata; v.rdata = rdata;
    v.rd = rd; v.rw = rw; v.delay = delay; v.exp_req = exp_req; v.exp_addr = exp_addr;
    v.exp_be = exp_be; v.exp_wdata = exp_wdata; v.exp_wb = exp_wb; v.exp_mis = exp_mis;
    v.exp_rw = exp_rw;
    return v;
  endfunction

  // Reference model: plain byte arithmetic on the access width and offset
  function automatic void model(inout vec_t v);
    int size;
    int off;
    longint mask;
    longint val;
    longint w;
    logic is_ld;
    is_ld = v.ld && !v.st;
    off = int'(v.addr % 4);
    if (v.st) size = (v.f3 == 3'd0) ? 1 : (v.f3 == 3'd1) ? 2 : 4;
    else if (v.f3 == 3'd0 || v.f3 == 3'd4) size = 1;
    else if (v.f3 == 3'd1 || v.f3 == 3'd5) size = 2;
    else size = 4;
    mask = (longint'(1) << (8 * size)) - 1;
    v.exp_mis = (is_ld || v.st) && (off % size != 0);
    v.exp_req = (is_ld || v.st) && !v.exp_mis;
    v.exp_addr = v.addr - 32'(off);
    v.exp_be = 4'(((1 << size) - 1) << off);
    w = 0;
    for (int i = 0; i < 4 / size; i++) w = w | ((longint'(v.sdata) & mask) << (8 * size * i));
    v.exp_wdata = w[31:0];
    val = (longint'(v.rdata) >> (8 * off)) & mask;
    if (size < 4 && (v.f3 == 3'd0 || v.f3 == 3'd1) && val[8*size-1]) val = val | ~mask;
    if (v.exp_mis) v.exp_wb = 32'd0;
    else if (is_ld) v.exp_wb = val[31:0];
    else v.exp_wb = v.addr;
    v.exp_rw = (v.exp_mis || v.st) ? 1'b0 : v.rw;
  endfunction

  // Present one instruction, service its memory access, and check the retire
  task automatic apply(input vec_t v, input string tag);
    int stall_cnt;
    logic hold_ok;
    ex_valid = 1'b1; ex_alu_result = v.addr; ex_store_data = v.sdata; ex_funct3 = v.f3;
    ex_mem_read = v.ld; ex_mem_write = v.st; ex_rd = v.rd; ex_reg_write = v.rw;
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    if (v.exp_req) begin
      chk({tag, " dmem_req"}, dmem_req, 1'b1);
      chk({tag, " dmem_addr"}, dmem_addr, v.exp_addr);
      chk({tag, " dmem_we"}, dmem_we, v.st);
      if (v.st) begin
        chk({tag, " dmem_be"}, dmem_be, v.exp_be);
        chk({tag, " dmem_wdata"}, dmem_wdata, v.exp_wdata);
      end
      stall_cnt = 0;
      hold_ok = 1'b1;
      for (int c = 1; c <= v.delay; c++) begin
        if (mem_stall) stall_cnt++;
        if (!dmem_req || dmem_addr !== v.exp_addr || wb_valid) hold_ok = 1'b0;
        dmem_ack = (c == v.delay);
        dmem_rdata = (c == v.delay) ? v.rdata : $urandom;
        @(posedge clk); #1;
      end
      dmem_ack = 1'b0;
      chk({tag, " req_hold"}, hold_ok, 1'b1);
      chk({tag, " stall_cycles"}, stall_cnt, v.delay);
      chk({tag, " req_drop"}, dmem_req, 1'b0);
    end else begin
      chk({tag, " no_req"}, dmem_req, 1'b0);
    end
    chk({tag, " stall_low"}, mem_stall, 1'b0);
    chk({tag, " wb_valid"}, wb_valid, 1'b1);
    chk({tag, " misalign"}, misalign, v.exp_mis);
    chk({tag, " wb_reg_write"}, wb_reg_write, v.exp_rw);
    if (!v.st || v.exp_mis) chk({tag, " wb_data"}, wb_data, v.exp_wb);
    if (!v.st && !v.exp_mis) chk({tag, " wb_rd"}, wb_rd, v.rd);
    $display("tx %s ld=%0b st=%0b f3=%0d addr=%h wb_data=%h mis=%0b", tag, v.ld, v.st, v.f3,
             v.addr, wb_data, misalign);
    @(posedge clk); #1;
    chk({tag, " wb_pulse"}, wb_valid, 1'b0);
    chk({tag, " mis_pulse"}, misalign, 1'b0);
  endtask

  vec_t tbl[14];
  vec_t rv;
  logic [31:0] s_addr[3];
  logic        s_ld[3];
  logic [4:0]  s_rd[3];
  logic [31:0] s_exp[3];

  initial begin
    rst = 1'b0; ex_valid = 1'b0; ex_alu_result = '0; ex_store_data = '0; ex_funct3 = '0;
    ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_rd = '0; ex_reg_write = 1'b0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    #2 rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("reset wb_valid", wb_valid, 1'b0);
    chk("reset dmem_req", dmem_req, 1'b0);
    chk("reset stall", mem_stall, 1'b0);
    chk("reset wb_data", wb_data, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    //             ld st f3    addr          sdata          rdata          rd  rw dly req addr          be       wdata          wb            mis rw
    tbl[0]  = mk(0, 0, 3'd0, 32'h0000_1234, 32'h0,         32'h0,         5,  1, 1, 0, 32'h0,        4'b0000, 32'h0,         32'h0000_1234, 0, 1);
    tbl[1]  = mk(0, 1, 3'd0, 32'h0000_0103, 32'h0000_00AB, 32'h0,         0,  1, 3, 1, 32'h100,      4'b1000, 32'hABAB_ABAB, 32'h0,         0, 0);
    tbl[2]  = mk(1, 0, 3'd0, 32'h0000_0102, 32'h0,         32'h0080_0000, 7,  1, 1, 1, 32'h100,      4'b0000, 32'h0,         32'hFFFF_FF80, 0, 1);
    tbl[3]  = mk(1, 0, 3'd4, 32'h0000_0102, 32'h0,         32'h0080_0000, 8,  1, 2, 1, 32'h100,      4'b0000, 32'h0,         32'h0000_0080, 0, 1);
    tbl[4]  = mk(1, 0, 3'd5, 32'h0000_0102, 32'h0,         32'hBEEF_0000, 9,  1, 1, 1, 32'h100,      4'b0000, 32'h0,         32'h0000_BEEF, 0, 1);
    tbl[5]  = mk(1, 0, 3'd2, 32'h0000_0106, 32'h0,         32'h0,         10, 1, 1, 0, 32'h0,        4'b0000, 32'h0,         32'h0,         1, 0);
    tbl[6]  = mk(0, 1, 3'd1, 32'h0000_0101, 32'h1234_5678, 32'h0,         11, 1, 1, 0, 32'h0,        4'b0000, 32'h0,         32'h0,         1, 0);
    tbl[7]  = mk(1, 0, 3'd1, 32'h0000_0100, 32'h0,         32'h0000_8001, 12, 1, 2, 1, 32'h100,      4'b0000, 32'h0,         32'hFFFF_8001, 0, 1);
    tbl[8]  = mk(0, 1, 3'd2, 32'h0000_0200, 32'hDEAD_BEEF, 32'h0,         0,  0, 1, 1, 32'h200,      4'b1111, 32'hDEAD_BEEF, 32'h0,         0, 0);
    tbl[9]  = mk(0, 1, 3'd1, 32'h0000_0202, 32'h1234_CAFE, 32'h0,         0,  0, 4, 1, 32'h200,      4'b1100, 32'hCAFE_CAFE, 32'h0,         0, 0);
    tbl[10] = mk(1, 0, 3'd2, 32'h0000_0300, 32'h0,         32'h1234_5678, 0,  1, 1, 1, 32'h300,      4'b0000, 32'h0,         32'h1234_5678, 0, 1);
    tbl[11] = mk(1, 0, 3'd7, 32'h0000_0304, 32'h0,         32'h89AB_CDEF, 13, 1, 2, 1, 32'h304,      4'b0000, 32'h0,         32'h89AB_CDEF, 0, 1);
    tbl[12] = mk(1, 1, 3'd0, 32'h0000_0010, 32'h0000_005A, 32'h0,         14, 1, 1, 1, 32'h010,      4'b0001, 32'h5A5A_5A5A, 32'h0,         0, 0);
    tbl[13] = mk(1, 0, 3'd0, 32'h0000_0101, 32'h0,         32'h0000_7F00, 15, 1, 1, 1, 32'h100,      4'b0000, 32'h0,         32'h0000_007F, 0, 1);

    for (int i = 0; i < 14; i++) apply(tbl[i], $sformatf("dir%0d", i));

    // Randomized vectors against the reference model
    for (int i = 0; i < 40; i++) begin
      int op;
      op = int'($urandom_range(0, 2));
      rv.ld = (op == 1); rv.st = (op == 2);
      rv.f3 = 3'($urandom_range(0, 7));
      rv.addr = $urandom; rv.sdata = $urandom; rv.rdata = $urandom;
      rv.rd = 5'($urandom_range(0, 31)); rv.rw = 1'($urandom_range(0, 1));
      rv.delay = int'($urandom_range(1, 4));
      model(rv);
      apply(rv, $sformatf("rnd%0d", i));
    end

    // Back-to-back ALU ops retire every cycle
    for (int i = 0; i < 4; i++) begin
      ex_valid = 1'b1; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
      ex_alu_result = 32'h100 + 32'(i); ex_rd = 5'(i + 1); ex_reg_write = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("b2b%0d wb_valid", i), wb_valid, 1'b1);
      chk($sformatf("b2b%0d wb_data", i), wb_data, 32'h100 + 32'(i));
      $display("tx b2b%0d wb_data=%h", i, wb_data);
    end
    ex_valid = 1'b0;
    @(posedge clk); #1;

    // Reset while a load is outstanding, then a stray ack after release
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_funct3 = 3'd2; ex_alu_result = 32'h400;
    ex_rd = 5'd6; ex_reg_write = 1'b1;
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_mem_read = 1'b0;
    chk("rstwait req", dmem_req, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rstwait req_async", dmem_req, 1'b0);
    chk("rstwait stall", mem_stall, 1'b0);
    chk("rstwait wb_data", wb_data, 32'd0);
    chk("rstwait wb_rd", wb_rd, 32'd0);
    chk("rstwait be", dmem_be, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    dmem_ack = 1'b1; dmem_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    chk("late_ack wb_valid", wb_valid, 1'b0);
    chk("late_ack req", dmem_req, 1'b0);
    $display("tx reset_in_wait wb_valid=%0b req=%0b", wb_valid, dmem_req);
    @(posedge clk); #1;

    // ALU, LW, ALU stream; upstream advances only when not stalled
    s_addr[0] = 32'h11;  s_ld[0] = 1'b0; s_rd[0] = 5'd1; s_exp[0] = 32'h11;
    s_addr[1] = 32'h40;  s_ld[1] = 1'b1; s_rd[1] = 5'd2; s_exp[1] = 32'hCAFE_0001;
    s_addr[2] = 32'h33;  s_ld[2] = 1'b0; s_rd[2] = 5'd3; s_exp[2] = 32'h33;
    begin
      int idx;
      int nret;
      int wcnt;
      logic stall_now;
      idx = 0; nret = 0; wcnt = 0;
      for (int cyc = 0; cyc < 30; cyc++) begin
        if (idx < 3) begin
          ex_valid = 1'b1; ex_alu_result = s_addr[idx]; ex_mem_read = s_ld[idx];
          ex_mem_write = 1'b0; ex_funct3 = 3'd2; ex_rd = s_rd[idx]; ex_reg_write = 1'b1;
        end else begin
          ex_valid = 1'b0; ex_mem_read = 1'b0;
        end
        if (dmem_req) wcnt++; else wcnt = 0;
        dmem_ack = dmem_req && (wcnt == 2);
        dmem_rdata = 32'hCAFE_0001;
        stall_now = mem_stall;
        @(posedge clk); #1;
        if (!stall_now && idx < 3) idx++;
        if (wb_valid) begin
          if (nret < 3) begin
            chk($sformatf("stream%0d wb_rd", nret), wb_rd, s_rd[nret]);
            chk($sformatf("stream%0d wb_data", nret), wb_data, s_exp[nret]);
            $display("tx stream%0d wb_rd=%0d wb_data=%h", nret, wb_rd, wb_data);
          end
          nret++;
        end
      end
      ex_valid = 1'b0; dmem_ack = 1'b0;
      chk("stream retire_count", nret, 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
